// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run/halt controller for the core enable flag. Debounces the board buttons,
//   turns them into single-cycle events, and issues resume/halt pulses. The
//   pulses start, stop or single/multi-step the core. In step mode the core is
//   kept enabled for exactly N cycles in which en_fb is high.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   btn_go         raw run/pause button (asynchronous)
//   btn_step       raw step button (asynchronous)
//   step_count     enabled cycles per step request, 0 behaves as 1
//   core_halt_req  core-originated halt request, level
//   bp_hit         breakpoint match, level
//   en_fb          current core enable flag
//   resume         resume pulse to the enable flag
//   halt           halt pulse to the enable flag
//   state          0=HALTED, 1=RUNNING, 2=STEPPING
//   steps_left     remaining enabled cycles of the current step
// -----------------------------------------------------------------------------

// Button conditioner: 2-FF synchroniser, debounce, rising-edge event.
module core_run_ctrl_btn #(
    parameter int DB_CYC = 1000,
    parameter int DB_W   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] db_cnt;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes the two-stage synchroniser actually two stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            evt    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            evt   <= 1'b0;
            if (sync2 != level) begin
                // DB_CYC consecutive differing samples accept the new level.
                if (db_cnt == DB_W'(DB_CYC - 1)) begin
                    level  <= sync2;
                    db_cnt <= '0;
                    evt    <= sync2;   // rising edge only
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end
endmodule

module core_run_ctrl #(
    parameter int STEP_W = 16,
    parameter int DB_CYC = 1000,
    parameter int DB_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_go,
    input  logic              btn_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              core_halt_req,
    input  logic              bp_hit,
    input  logic              en_fb,
    output logic              resume,
    output logic              halt,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] steps_left
);
    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUNNING  = 2'd1,
        S_STEPPING = 2'd2
    } run_state_t;

    run_state_t        state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              go_evt;
    logic              step_evt;
    logic              stop;

    core_run_ctrl_btn #(.DB_CYC(DB_CYC), .DB_W(DB_W)) u_btn_go (
        .clk (clk),
        .rst (rst),
        .raw (btn_go),
        .evt (go_evt)
    );

    core_run_ctrl_btn #(.DB_CYC(DB_CYC), .DB_W(DB_W)) u_btn_step (
        .clk (clk),
        .rst (rst),
        .raw (btn_step),
        .evt (step_evt)
    );

    // Reset lands in RUNNING to match the enable flag's reset value of 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUNNING;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stop = go_evt | core_halt_req | bp_hit;

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resume  = 1'b0;
        halt    = 1'b0;
        unique case (state_q)
            S_HALTED: begin
                if (go_evt) begin
                    resume  = 1'b1;
                    state_d = S_RUNNING;
                end else if (step_evt) begin
                    resume  = 1'b1;
                    cnt_d   = (step_count == '0) ? STEP_W'(1) : step_count;
                    state_d = S_STEPPING;
                end
            end
            S_RUNNING: begin
                if (stop) begin
                    halt    = 1'b1;
                    state_d = S_HALTED;
                end
            end
            S_STEPPING: begin
                // Abort beats completion; a stalled core (en_fb=0) freezes the count.
                if (stop || (en_fb && cnt_q == STEP_W'(1))) begin
                    halt    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HALTED;
                end else if (en_fb) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
        // Level inputs decode straight into pulses, so hold them quiet while in reset.
        if (rst) begin
            resume = 1'b0;
            halt   = 1'b0;
        end
    end

    assign state      = state_q;
    assign steps_left = cnt_q;
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/halt controller at the far end of the core-enable protocol: it issues the resume and halt pulses consumed by the core enable flag, and observes that flag as en_fb.
- Turns board buttons (run/pause, single/multi-step) plus core halt requests and breakpoint hits into correctly timed pulses.
- Multi-step mode leaves the core enabled for exactly N cycles.
- Sits beside the core enable flag at top level; en_fb is that flag's output.

Parameters:
STEP_W, 16, width of step count and step counter
DB_CYC, 1000, consecutive stable samples needed to accept a button level change (>=2)
DB_W, 10, debounce counter width, must satisfy 2^DB_W > DB_CYC

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_go  in  1  raw run/pause button, asynchronous to clk
btn_step  in  1  raw step button, asynchronous to clk
step_count  in  STEP_W  cycles per step request; 0 treated as 1
core_halt_req  in  1  core-originated halt request (e.g. halt syscall), level sampled each cycle
bp_hit  in  1  breakpoint match, level sampled each cycle
en_fb  in  1  current core enable flag
resume  out  1  resume pulse to the core enable flag
halt  out  1  halt pulse to the core enable flag
state  out  2  0=HALTED, 1=RUNNING, 2=STEPPING
steps_left  out  STEP_W  remaining enabled cycles in the current step

Behaviour:
- Reset (async, active-high): state=RUNNING, matching the enable flag's reset value of 1. Also cleared to 0: step counter, synchronisers, debounce counters, debounced levels and event flags. Outputs during and after reset: resume=0, halt=0, steps_left=0.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce: counter increments while sync output differs from debounced level, else clears to 0. When the counter reaches DB_CYC-1 and the levels still differ, debounced level takes the sync value and the counter clears.
  - Event flag: registered 1-cycle pulse on the debounced rising edge (go_evt, step_evt). Falling edges generate nothing.
- resume and halt are combinational decodes of registered state, step counter, event flags, en_fb, core_halt_req and bp_hit. They are never high in the same cycle.
- HALTED:
  - go_evt -> resume=1; next state RUNNING.
  - else step_evt -> resume=1; counter <= (step_count==0 ? 1 : step_count); next state STEPPING.
  - core_halt_req, bp_hit: ignored.
- RUNNING:
  - go_evt | core_halt_req | bp_hit -> halt=1 (single pulse even if several are set); next state HALTED.
  - step_evt: ignored.
- STEPPING:
  - go_evt | core_halt_req | bp_hit -> halt=1; counter <= 0; next state HALTED (abort). Abort has priority over normal completion.
  - else if en_fb and counter==1 -> halt=1; counter <= 0; next state HALTED.
  - else if en_fb -> counter decrements.
  - en_fb=0 (core stalled by another agent) -> counter holds, no pulse.
  - step_evt: ignored.
- Timing: resume in cycle t makes the core enabled from t+1. The completion halt then falls in cycle t+N, so en_fb is high for exactly N cycles (t+1..t+N).
- steps_left = counter; state = encoded FSM state.
- Reset asserted mid-step: immediate return to reset values; no halt pulse is generated.

Test Plan:
1. Reset, release; core_halt_req=1 in cycle 5 only -> halt=1 in cycle 5 only, state=HALTED from cycle 6; a core_halt_req pulse in cycle 9 produces no halt.
2. DB_CYC=4, in HALTED: btn_go high for 3 cycles then low -> no resume. Then btn_go held high 10 cycles -> exactly one resume pulse, state=RUNNING. Release and press again after >=4 cycles -> exactly one halt pulse.
3. HALTED, step_count=3, core enable model driving en_fb, btn_step pressed -> resume, then en_fb high exactly 3 cycles; halt coincides with the 3rd; state=HALTED, steps_left=0.
4. step_count=0, step press -> en_fb high exactly 1 cycle, with halt in that same cycle.
5. step_count=10, bp_hit=1 on the 4th enabled cycle -> halt in that cycle, en_fb high 4 cycles total, steps_left=0, state=HALTED.
6. go_evt and step_evt in the same HALTED cycle -> RUNNING, counter stays 0. Later, while STEPPING with steps_left=5, assert rst -> resume=halt=0, state=RUNNING, steps_left=0.
